ascii_hex_word: RTL and testbench
=================================

# ascii_hex_word

Parametrised ASCII-hex word assembler for the UART receive path. It takes a stream of ASCII bytes and converts each hex character to a nibble, packing nibbles MSB-first into a word of `NDIG` digits. A word is emitted when `NDIG` digits have arrived, or earlier when a separator character ends it. Non-hex, non-separator characters raise an error pulse and discard the partial word. It sits between the UART RX byte output and the command/register-write logic of the temperature monitor.

## Interface
Parameters:
- `NDIG`, default 4: hex digits per word, must be ≥1. Output word width is `DW = 4*NDIG`.
- `LC_EN`, default 1: 1 accepts `a`–`f`; 0 treats lowercase letters as invalid characters.
- `CW`, derived as `$clog2(NDIG+1)`: width of the digit-count output.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `din`  in  8  ASCII byte.
- `din_vld`  in  1  `din` valid for this cycle; one byte consumed per valid cycle, no backpressure.
- `dout`  out  DW  assembled word, right-aligned, zero-extended.
- `dout_vld`  out  1  one-cycle pulse; `dout`/`dout_cnt` valid.
- `dout_cnt`  out  CW  number of digits in the emitted word, from 1 to `NDIG`.
- `err`  out  1  one-cycle pulse on an invalid character.

## Operation
Character classes are decoded only when `din_vld`=1:
- **HEX**:
  - `0x30`–`0x39` maps to `din-48`.
  - `0x41`–`0x46` maps to `din-55`.
  - `0x61`–`0x66` maps to `din-87`, only if `LC_EN`=1.
- **SEP**: `0x0D` (CR), `0x0A` (LF), `0x20` (space), `0x2C` (comma).
- **BAD**: every other byte, plus lowercase `a`–`f` when `LC_EN`=0.

State: accumulator `acc[DW-1:0]` and digit counter `cnt[CW-1:0]`. There are two states:
- **IDLE**: `cnt`=0.
- **ACC**: 1 ≤ `cnt` < `NDIG`.

Transitions on a `din_vld` cycle:
- HEX, with `cnt+1` < `NDIG`:
  - `acc` ← `{acc[DW-5:0], nib}`, `cnt`++.
  - Enter or stay in ACC.
- HEX, with `cnt+1` == `NDIG`:
  - `dout` ← `{acc[DW-5:0], nib}`, `dout_cnt` ← `NDIG`, `dout_vld` ← 1.
  - `acc` ← 0, `cnt` ← 0, go to IDLE.
  - With `NDIG`=1, every hex digit emits immediately.
- SEP in ACC:
  - `dout` ← `acc`, `dout_cnt` ← `cnt`, `dout_vld` ← 1.
  - `acc` ← 0, `cnt` ← 0, go to IDLE.
- SEP in IDLE: no action. Consecutive separators or a leading separator emit nothing.
- BAD in any state:
  - `err` ← 1.
  - `acc` ← 0, `cnt` ← 0, go to IDLE.
  - No `dout_vld`.

Other rules:
- `din_vld`=0: state holds; `dout_vld` and `err` go to 0 next cycle.
- `dout` and `dout_cnt` hold their last emitted value between pulses; they are not cleared.
- Arithmetic: the nibble is the low 4 bits of the 8-bit subtraction. Zero-extension of short words comes from the `acc` clear.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release):
  - `dout`=0, `dout_cnt`=0, `dout_vld`=0, `err`=0, `acc`=0, `cnt`=0, state IDLE.
- Latency:
  - `dout_vld` and `err` assert exactly 1 cycle after the `din_vld` cycle carrying the final digit, separator or bad byte.
  - Each is high for exactly 1 cycle per event.
- Throughput: one byte per cycle sustained. Back-to-back `din_vld` streams `NDIG` digits long emit a pulse every `NDIG` cycles. The byte following an emitting byte starts the next word in the very next cycle, without loss.
- `dout_vld` and `err` are never high in the same cycle.
- Reset asserted mid-word discards the partial word with no output pulse.

## Test plan
- `NDIG`=4, `din_vld` on "1","A","3","F" in consecutive cycles → 1 cycle after "F": `dout_vld`=1, `dout`=16'h1A3F, `dout_cnt`=4. No pulse earlier.
- `NDIG`=4: "7","b",CR → `dout`=16'h007B, `dout_cnt`=2, 1 cycle after CR. A following LF produces no pulse.
- `NDIG`=4: "1","2","G","3",LF → `err` pulse 1 cycle after "G", no `dout_vld` for it; then `dout`=16'h0003, `dout_cnt`=1 after LF.
- `LC_EN`=0: "a" → `err`=1, no `dout_vld`. `LC_EN`=1: "a",space → `dout`=16'h000A, `dout_cnt`=1.
- `NDIG`=4: continuous "ABCD1234" with no gaps → `dout_vld` pulses exactly 4 cycles apart, with `dout`=16'hABCD then 16'h1234. `NDIG`=1: "5","E" → two consecutive pulses, values 4'h5, 4'hE.
- "1","2", then `rst_n` low for 2 cycles → all outputs 0, no `dout_vld`. After release, "3","4",LF → `dout`=16'h0034, `dout_cnt`=2.

Source files
------------

// File: rtl/ascii_hex_word.sv
// ASCII-hex word assembler for the UART receive path.
// Converts a stream of ASCII hex characters into words of NDIG digits.
// Digits are packed MSB-first. A word is emitted when it is full, or
// earlier when a separator ends it. An invalid byte raises a one-cycle
// error pulse and drops the partial word.
module ascii_hex_word #(
    parameter  int NDIG  = 4,
    parameter  int LC_EN = 1,
    localparam int DW    = 4 * NDIG,
    localparam int CW    = $clog2(NDIG + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    din,
    input  logic          din_vld,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic [CW-1:0] dout_cnt,
    output logic          err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // Digit count that completes a word, one bit wider than cnt so that
    // cnt+1 never wraps before the comparison.
    localparam logic [CW:0]   NDIG_W = (CW + 1)'(NDIG);
    localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

    // Character decode: {is_hex, is_sep, nibble}. All-zero means the byte is invalid.
    function automatic logic [5:0] classify(input logic [7:0] c);
        logic [5:0] r;
        logic [7:0] d;
        r = 6'b00_0000;
        d = 8'h00;
        if ((c >= 8'h30) && (c <= 8'h39)) begin
            d = c - 8'd48;
            r = {2'b10, d[3:0]};
        end else if ((c >= 8'h41) && (c <= 8'h46)) begin
            d = c - 8'd55;
            r = {2'b10, d[3:0]};
        end else if ((LC_EN != 0) && (c >= 8'h61) && (c <= 8'h66)) begin
            d = c - 8'd87;
            r = {2'b10, d[3:0]};
        end else if ((c == 8'h0D) || (c == 8'h0A) || (c == 8'h20) || (c == 8'h2C)) begin
            r = {2'b01, 4'h0};
        end else begin
            r = 6'b00_0000;
        end
        return r;
    endfunction

    state_t        state_r, state_n;
    logic [DW-1:0] acc_r, acc_n;
    logic [CW-1:0] cnt_r, cnt_n;
    logic [DW-1:0] dout_r, dout_n;
    logic [CW-1:0] dout_cnt_r, dout_cnt_n;
    logic          dout_vld_r, dout_vld_n;
    logic          err_r, err_n;

    logic [5:0]    cls_s;
    logic          is_hex_s;
    logic          is_sep_s;
    logic [3:0]    nib_s;
    logic [DW-1:0] acc_shift_s;
    logic [CW:0]   cnt_inc_s;

    assign cls_s       = classify(din);
    assign is_hex_s    = cls_s[5];
    assign is_sep_s    = cls_s[4];
    assign nib_s       = cls_s[3:0];
    // Shift in the new nibble at the bottom; the top nibble drops out.
    assign acc_shift_s = DW'({acc_r, nib_s});
    assign cnt_inc_s   = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};

    // Next-state and next-output decode for one consumed byte.
    always_comb begin
        state_n    = state_r;
        acc_n      = acc_r;
        cnt_n      = cnt_r;
        dout_n     = dout_r;
        dout_cnt_n = dout_cnt_r;
        dout_vld_n = 1'b0;
        err_n      = 1'b0;
        if (din_vld) begin
            if (is_hex_s) begin
                if (cnt_inc_s == NDIG_W) begin
                    dout_n     = acc_shift_s;
                    dout_cnt_n = NDIG_C;
                    dout_vld_n = 1'b1;
                    acc_n      = {DW{1'b0}};
                    cnt_n      = {CW{1'b0}};
                    state_n    = ST_IDLE;
                end else begin
                    acc_n   = acc_shift_s;
                    cnt_n   = cnt_inc_s[CW-1:0];
                    state_n = ST_ACC;
                end
            end else if (is_sep_s) begin
                case (state_r)
                    ST_ACC: begin
                        dout_n     = acc_r;
                        dout_cnt_n = cnt_r;
                        dout_vld_n = 1'b1;
                        acc_n      = {DW{1'b0}};
                        cnt_n      = {CW{1'b0}};
                        state_n    = ST_IDLE;
                    end
                    ST_IDLE: begin
                        state_n = ST_IDLE;
                    end
                    default: begin
                        acc_n   = {DW{1'b0}};
                        cnt_n   = {CW{1'b0}};
                        state_n = ST_IDLE;
                    end
                endcase
            end else begin
                err_n   = 1'b1;
                acc_n   = {DW{1'b0}};
                cnt_n   = {CW{1'b0}};
                state_n = ST_IDLE;
            end
        end else begin
            state_n = state_r;
        end
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            acc_r      <= {DW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            dout_r     <= {DW{1'b0}};
            dout_cnt_r <= {CW{1'b0}};
            dout_vld_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            acc_r      <= acc_n;
            cnt_r      <= cnt_n;
            dout_r     <= dout_n;
            dout_cnt_r <= dout_cnt_n;
            dout_vld_r <= dout_vld_n;
            err_r      <= err_n;
        end
    end

    assign dout     = dout_r;
    assign dout_cnt = dout_cnt_r;
    assign dout_vld = dout_vld_r;
    assign err      = err_r;

endmodule

// File: tb/tb_ascii_hex_word.sv
// Testbench for ascii_hex_word: three instances (NDIG=4/LC_EN=1,
// NDIG=4/LC_EN=0, NDIG=1/LC_EN=1) share one byte stream. Each is
// compared every cycle against a digit-list reference model.
module tb_ascii_hex_word;

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_vld;

    logic [15:0] dout_a, dout_b;
    logic [3:0]  dout_c;
    logic [2:0]  cnt_a, cnt_b;
    logic [0:0]  cnt_c;
    logic        vld_a, vld_b, vld_c;
    logic        err_a, err_b, err_c;

    int n_assert;
    int n_fail;

    // Reference model state: the list of digits received so far, per instance.
    int          ndig_m[3];
    int          lc_m[3];
    int          digs[3][4];
    int          nd[3];
    logic [15:0] exp_dout[3];
    int          exp_cnt[3];
    logic        exp_vld[3];
    logic        exp_err[3];

    ascii_hex_word #(.NDIG(4), .LC_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .dout(dout_a), .dout_vld(vld_a), .dout_cnt(cnt_a), .err(err_a));

    ascii_hex_word #(.NDIG(4), .LC_EN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .dout(dout_b), .dout_vld(vld_b), .dout_cnt(cnt_b), .err(err_b));

    ascii_hex_word #(.NDIG(1), .LC_EN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .dout(dout_c), .dout_vld(vld_c), .dout_cnt(cnt_c), .err(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hex value of an ASCII byte, -1 if it is not a hex digit, -2 if it is a separator.
    function automatic int char_kind(input int c, input int lc);
        if (c >= 48 && c <= 57) return c - 48;
        if (c >= 65 && c <= 70) return c - 55;
        if (lc != 0 && c >= 97 && c <= 102) return c - 87;
        if (c == 13 || c == 10 || c == 32 || c == 44) return -2;
        return -1;
    endfunction

    task automatic model_emit(input int i);
        int w;
        w = 0;
        for (int k = 0; k < nd[i]; k++) w = w * 16 + digs[i][k];
        exp_dout[i] = 16'(w);
        exp_cnt[i]  = nd[i];
        exp_vld[i]  = 1'b1;
        nd[i]       = 0;
    endtask

    task automatic model_byte(input int b, input logic v);
        int k;
        for (int i = 0; i < 3; i++) begin
            exp_vld[i] = 1'b0;
            exp_err[i] = 1'b0;
            if (v) begin
                k = char_kind(b, lc_m[i]);
                if (k >= 0) begin
                    digs[i][nd[i]] = k;
                    nd[i]++;
                    if (nd[i] == ndig_m[i]) model_emit(i);
                end else if (k == -2) begin
                    if (nd[i] > 0) model_emit(i);
                end else begin
                    nd[i]      = 0;
                    exp_err[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            nd[i]       = 0;
            exp_dout[i] = 16'h0000;
            exp_cnt[i]  = 0;
            exp_vld[i]  = 1'b0;
            exp_err[i]  = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_vld",  16'(vld_a),  16'(exp_vld[0]));
        chk("a_err",  16'(err_a),  16'(exp_err[0]));
        chk("a_dout", dout_a,      exp_dout[0]);
        chk("a_cnt",  16'(cnt_a),  16'(exp_cnt[0]));
        chk("b_vld",  16'(vld_b),  16'(exp_vld[1]));
        chk("b_err",  16'(err_b),  16'(exp_err[1]));
        chk("b_dout", dout_b,      exp_dout[1]);
        chk("b_cnt",  16'(cnt_b),  16'(exp_cnt[1]));
        chk("c_vld",  16'(vld_c),  16'(exp_vld[2]));
        chk("c_err",  16'(err_c),  16'(exp_err[2]));
        chk("c_dout", 16'(dout_c), 16'(exp_dout[2][3:0]));
        chk("c_cnt",  16'(cnt_c),  16'(exp_cnt[2]));
    endtask

    task automatic step(input int b, input logic v);
        @(negedge clk);
        din     = 8'(b);
        din_vld = v;
        model_byte(b, v);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(int'(s[i]), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n   = 1'b0;
        din_vld = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        string pool;
        string seps;
        int    r;
        int    b;
        logic  v;

        n_assert  = 0;
        n_fail    = 0;
        ndig_m[0] = 4; ndig_m[1] = 4; ndig_m[2] = 1;
        lc_m[0]   = 1; lc_m[1]   = 0; lc_m[2]   = 1;
        rst_n     = 1'b0;
        din       = 8'h00;
        din_vld   = 1'b0;
        model_reset();
        pool = "0123456789ABCDEFabcdef";
        seps = "\r\n ,";

        // Reset state.
        do_reset(2);
        idle(1);

        // "1A3F" back to back forms one full word.
        send_str("1A3F");
        chk("tp_1a3f", dout_a, 16'h1A3F);
        chk("tp_1a3f_cnt", 16'(cnt_a), 16'd4);
        idle(2);

        // Short word ended by CR; a following LF emits nothing.
        send_str("7b\r");
        chk("tp_7b", dout_a, 16'h007B);
        chk("tp_7b_cnt", 16'(cnt_a), 16'd2);
        send_str("\n");
        chk("tp_lf_quiet", 16'(vld_a), 16'd0);
        idle(1);

        // Bad character mid-word.
        send_str("12G");
        chk("tp_g_err", 16'(err_a), 16'd1);
        send_str("3\n");
        chk("tp_3", dout_a, 16'h0003);
        idle(1);

        // Lowercase handling; instance b rejects it.
        send_str("a");
        chk("tp_lc0_err", 16'(err_b), 16'd1);
        send_str(" ");
        chk("tp_lc1_a", dout_a, 16'h000A);
        idle(1);

        // Sustained stream, plus leading/double separators.
        send_str("ABCD1234");
        chk("tp_1234", dout_a, 16'h1234);
        send_str(",, 5E");
        chk("tp_n1_e", 16'(dout_c), 16'h000E);
        idle(1);

        // Reset mid-word discards the partial word.
        send_str("12");
        do_reset(2);
        send_str("34\n");
        chk("tp_34", dout_a, 16'h0034);
        chk("tp_34_cnt", 16'(cnt_a), 16'd2);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5)      b = int'(pool[int'($urandom_range(0, 21))]);
            else if (r <= 7) b = int'(seps[int'($urandom_range(0, 3))]);
            else             b = int'($urandom_range(0, 255));
            v = ($urandom_range(0, 3) != 0);
            step(b, v);
            if (n == 300) do_reset(1);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
